// File: rtl/dgldpc_pkg.sv
// Shared types and default widths for the GLDPC VNU scheduler.
// Pipeline entries carry a fixed-width address so one struct fits every instance.
package dgldpc_pkg;

  localparam int DEF_N_VG     = 16;
  localparam int DEF_VNU_LAT  = 2;
  localparam int DEF_MAX_ITER = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_N_VG);
  localparam int DEF_ITER_W   = $clog2(DEF_MAX_ITER + 1);
  localparam int PIPE_ADDR_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_ADDR_W-1:0] addr;
  } pipe_entry_t;

endpackage

// File: rtl/dgldpc_addr_pipe.sv
// Delay line of {valid, addr} matching the VNU latency, with flush and
// per-stage address compare used for read-after-write hazard detection.
module dgldpc_addr_pipe
  import dgldpc_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic [DEPTH-1:0]  hit_o,
  output logic              pend_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  pipe_entry_t            stage_q [DEPTH];
  pipe_entry_t            in_ent;
  logic [PIPE_ADDR_W-1:0] cmp_ext;

  always_comb begin
    in_ent                    = '0;
    in_ent.valid              = valid_i;
    in_ent.addr[ADDR_W-1:0]   = addr_i;
    cmp_ext                   = '0;
    cmp_ext[ADDR_W-1:0]       = cmp_addr_i;
  end

  // NOTE: only the valid bits carry meaning, but clearing whole entries keeps every output at 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain independent of loop order.
      stage_q[0] <= in_ent;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // pend_o looks one cycle ahead: entries that will still be valid after this edge.
  always_comb begin
    hit_o  = '0;
    pend_o = valid_i;
    for (int i = 0; i < DEPTH; i++)
      hit_o[i] = stage_q[i].valid && (stage_q[i].addr == cmp_ext);
    for (int i = 0; i < DEPTH - 1; i++)
      pend_o = pend_o | stage_q[i].valid;
  end

  assign wr_valid_o = stage_q[DEPTH-1].valid && !flush_i;
  assign wr_addr_o  = wr_valid_o ? stage_q[DEPTH-1].addr[ADDR_W-1:0] : '0;

endmodule

// File: rtl/dgldpc_vnu_scheduler.sv
// Shuffled-schedule VNU sequencer: issues group reads, stalls on in-flight
// write-backs, and retires the write-back address after the VNU latency.
module dgldpc_vnu_scheduler
  import dgldpc_pkg::*;
#(
  parameter int N_VG     = DEF_N_VG,
  parameter int VNU_LAT  = DEF_VNU_LAT,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ADDR_W   = (N_VG > 1) ? $clog2(N_VG) : 1,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_early_stop,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ITER_W-1:0] o_iter,
  output logic              o_done,
  output logic              o_success
);

  localparam int                PIPE      = VNU_LAT + 1;
  localparam logic [ADDR_W-1:0] LAST_GRP  = ADDR_W'(N_VG - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] grp_q, grp_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              success_q, success_d;
  logic [PIPE-1:0]   hit;
  logic              hazard, pend, rd_en, flush, busy, done;

  assign hazard = |hit;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    iter_d    = iter_q;
    success_d = success_q;
    rd_en     = 1'b0;
    flush     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_RUN;
          grp_d     = '0;
          iter_d    = '0;
          success_d = 1'b0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (i_early_stop) begin
          success_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (!hazard) begin
          rd_en = 1'b1;
          if (grp_q == LAST_GRP) begin
            grp_d = '0;
            if (iter_q == LAST_ITER) state_d = S_DRAIN;
            else                     iter_d  = iter_q + 1'b1;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!pend) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything above, including this cycle's read and completion.
    if (i_abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      grp_d     = grp_q;
      iter_d    = iter_q;
      success_d = success_q;
      rd_en     = 1'b0;
      done      = 1'b0;
      flush     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grp_q     <= '0;
      iter_q    <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      iter_q    <= iter_d;
      success_q <= success_d;
    end
  end

  dgldpc_addr_pipe #(
    .DEPTH (PIPE),
    .ADDR_W(ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .valid_i   (rd_en),
    .addr_i    (grp_q),
    .cmp_addr_i(grp_q),
    .hit_o     (hit),
    .pend_o    (pend),
    .wr_valid_o(o_wr_en),
    .wr_addr_o (o_wr_addr)
  );

  assign o_busy    = busy;
  assign o_rd_en   = rd_en;
  assign o_rd_addr = rd_en ? grp_q : '0;
  assign o_iter    = iter_q;
  assign o_done    = done;
  assign o_success = success_q;

endmodule

// File: tb/tb_dgldpc_vnu_scheduler.sv
// Scoreboard bench: two scheduler configurations share one stimulus stream and
// are each checked against a schedule computed from the group/iteration rules.
module tb_dgldpc_vnu_scheduler;

  localparam int PIPE = 3;

  typedef struct {
    int cyc;
    int addr;
    int iter;
  } ev_t;

  logic clk = 1'b0;
  logic rst, i_start, i_early_stop, i_abort;

  logic       a_busy, a_rd_en, a_wr_en, a_done, a_success;
  logic [3:0] a_rd_addr, a_wr_addr, a_iter;
  logic       b_busy, b_rd_en, b_wr_en, b_done, b_success;
  logic [0:0] b_rd_addr, b_wr_addr;
  logic [1:0] b_iter;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  ev_t rd_q[2][$];
  ev_t wr_q[2][$];
  ev_t dn_q[2][$];
  int  busy_lo[2] = '{0, 0};
  int  busy_hi[2] = '{0, 0};

  dgldpc_vnu_scheduler #(.N_VG(16), .VNU_LAT(2), .MAX_ITER(8)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_early_stop(i_early_stop), .i_abort(i_abort),
    .o_busy(a_busy), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr), .o_wr_en(a_wr_en),
    .o_wr_addr(a_wr_addr), .o_iter(a_iter), .o_done(a_done), .o_success(a_success));

  dgldpc_vnu_scheduler #(.N_VG(2), .VNU_LAT(2), .MAX_ITER(3)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_early_stop(i_early_stop), .i_abort(i_abort),
    .o_busy(b_busy), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .o_wr_en(b_wr_en),
    .o_wr_addr(b_wr_addr), .o_iter(b_iter), .o_done(b_done), .o_success(b_success));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nvg(input int d);
    return (d == 0) ? 16 : 2;
  endfunction

  function automatic int maxit(input int d);
    return (d == 0) ? 8 : 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference schedule: a group may be read again only after its previous
  // write-back cycle (read + PIPE) has passed. Times are relative to the start cycle.
  task automatic model(input int d, input int base, input int stop_t, input int abort_t,
                       output int len);
    int  n, mi, t, g, it, lr, dn;
    int  last[16];
    bit  aborted, succ;
    ev_t rd_loc[$];
    n = nvg(d); mi = maxit(d);
    t = 1; g = 0; it = 0; lr = -1000; aborted = 0; succ = 0;
    for (int i = 0; i < 16; i++) last[i] = -1000;
    while (t < 20000) begin
      if (t == abort_t) begin aborted = 1; break; end
      if (t == stop_t) begin succ = 1; break; end
      if (t - last[g] > PIPE) begin
        rd_loc.push_back('{t, g, it});
        last[g] = t;
        lr = t;
        if (g == n - 1) begin
          g = 0;
          if (it == mi - 1) break;
          it++;
        end else begin
          g++;
        end
      end
      t++;
    end
    dn = (t + 2 > lr + PIPE + 1) ? t + 2 : lr + PIPE + 1;
    if (!aborted && abort_t > t && abort_t <= dn) aborted = 1;
    foreach (rd_loc[i]) begin
      rd_q[d].push_back('{base + rd_loc[i].cyc, rd_loc[i].addr, rd_loc[i].iter});
      if (!aborted || rd_loc[i].cyc + PIPE < abort_t)
        wr_q[d].push_back('{base + rd_loc[i].cyc + PIPE, rd_loc[i].addr, 0});
    end
    busy_lo[d] = base + 1;
    if (aborted) begin
      busy_hi[d] = base + abort_t + 1;
      len = abort_t + 1;
    end else begin
      busy_hi[d] = base + dn;
      dn_q[d].push_back('{base + dn, int'(succ), it});
      len = dn + 1;
    end
  endtask

  task automatic mon(input int d, input logic busy, input logic rd_en, input int rd_addr,
                     input logic wr_en, input int wr_addr, input int iter,
                     input logic done, input logic succ);
    ev_t e;
    bit  exp;
    exp = (rd_q[d].size() > 0) && (rd_q[d][0].cyc == cyc);
    check($sformatf("d%0d rd_en c%0d", d, cyc), int'(rd_en), int'(exp));
    if (exp) begin
      e = rd_q[d].pop_front();
      if (rd_en) begin
        check($sformatf("d%0d rd_addr c%0d", d, cyc), rd_addr, e.addr);
        check($sformatf("d%0d rd_iter c%0d", d, cyc), iter, e.iter);
      end
    end
    exp = (wr_q[d].size() > 0) && (wr_q[d][0].cyc == cyc);
    check($sformatf("d%0d wr_en c%0d", d, cyc), int'(wr_en), int'(exp));
    if (exp) begin
      e = wr_q[d].pop_front();
      if (wr_en) check($sformatf("d%0d wr_addr c%0d", d, cyc), wr_addr, e.addr);
    end
    exp = (dn_q[d].size() > 0) && (dn_q[d][0].cyc == cyc);
    check($sformatf("d%0d done c%0d", d, cyc), int'(done), int'(exp));
    if (exp) begin
      e = dn_q[d].pop_front();
      if (done) begin
        check($sformatf("d%0d success c%0d", d, cyc), int'(succ), e.addr);
        check($sformatf("d%0d final_iter c%0d", d, cyc), iter, e.iter);
      end
    end
    check($sformatf("d%0d busy c%0d", d, cyc), int'(busy),
          int'(cyc >= busy_lo[d] && cyc < busy_hi[d]));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a_busy, a_rd_en, int'(a_rd_addr), a_wr_en, int'(a_wr_addr), int'(a_iter),
          a_done, a_success);
      mon(1, b_busy, b_rd_en, int'(b_rd_addr), b_wr_en, int'(b_wr_addr), int'(b_iter),
          b_done, b_success);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a_out"}, int'({a_busy, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_iter,
                                 a_done, a_success}), 0);
    check({tag, " b_out"}, int'({b_busy, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_iter,
                                 b_done, b_success}), 0);
  endtask

  task automatic check_drained(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s d%0d pending", tag, d),
            rd_q[d].size() + wr_q[d].size() + dn_q[d].size(), 0);
  endtask

  task automatic scenario(input int stop_t, input int abort_t, input int spur_t);
    int base, len0, len1, len;
    base = cyc;
    model(0, base, stop_t, abort_t, len0);
    model(1, base, stop_t, abort_t, len1);
    len = ((len0 > len1) ? len0 : len1) + 3;
    for (int t = 0; t < len; t++) begin
      i_start      = (t == 0) || (t == spur_t);
      i_early_stop = (t == stop_t);
      i_abort      = (t == abort_t);
      step();
    end
    i_start = 1'b0; i_early_stop = 1'b0; i_abort = 1'b0;
    check_drained("scenario");
  endtask

  initial begin
    int base, len0, len1, s, a;
    rst = 1'b1; i_start = 1'b0; i_early_stop = 1'b0; i_abort = 1'b0;
    repeat (2) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    scenario(-1, -1, -1);           // full run to MAX_ITER on both configs
    scenario(40, -1, -1);           // early stop
    scenario(-1, 20, -1);           // abort mid-run
    i_early_stop = 1'b1; step(); i_early_stop = 1'b0;
    step();
    scenario(-1, -1, 3);            // stray start in RUN, stray stop in IDLE

    // Asynchronous reset between clock edges while dut_a is mid-run.
    base = cyc;
    model(0, base, -1, -1, len0);
    model(1, base, -1, -1, len1);
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (49) step();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    for (int d = 0; d < 2; d++) begin
      rd_q[d].delete(); wr_q[d].delete(); dn_q[d].delete();
      busy_hi[d] = 0;
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    repeat (10) step();
    check_zero("post_rst_idle");

    for (int k = 0; k < 6; k++) begin
      s = ($urandom_range(1, 0) == 1) ? int'($urandom_range(150, 6)) : -1;
      a = ($urandom_range(1, 0) == 1) ? int'($urandom_range(150, 6)) : -1;
      scenario(s, a, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dgldpc_vnu_scheduler.md
Name: dgldpc_vnu_scheduler

Overview:
Sequencer for the shuffled-schedule variable-node unit (VNU) of the GLDPC decoder. It walks the variable-node groups of a codeword over up to MAX_ITER iterations and issues message-memory read addresses into the VNU datapath. It delays each address through a pipeline that matches the VNU latency, then issues the write-back address. Because the schedule is shuffled, iterations run back-to-back without draining, so the block also stalls any read that would hit a group whose write-back is still in flight.

Parameters:
N_VG, 16, number of variable-node groups per codeword (>=1)
VNU_LAT, 2, VNU register stages between read data and write data (>=0)
MAX_ITER, 8, maximum decoding iterations (>=1)
ADDR_W, $clog2(N_VG) (min 1), group address width
ITER_W, $clog2(MAX_ITER+1), iteration counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_start  in  1  start pulse, accepted only in IDLE
i_early_stop  in  1  syndrome checker reports all checks satisfied (pulse)
i_abort  in  1  abort decode, flush pipeline
o_busy  out  1  high from start acceptance until o_done
o_rd_en  out  1  message/LLR read strobe
o_rd_addr  out  ADDR_W  group being read
o_wr_en  out  1  VNU write-back strobe
o_wr_addr  out  ADDR_W  group being written
o_iter  out  ITER_W  current iteration index (0-based)
o_done  out  1  one-cycle completion pulse
o_success  out  1  valid with o_done: 1 = early stop, 0 = MAX_ITER exhausted

Behaviour:
- Reset: all outputs 0, FSM = IDLE, pipeline valid bits cleared, counters 0. The reset is asynchronous, and its deassertion is treated as synchronous to clk.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on i_start go to RUN next cycle and set o_busy. The group counter and o_iter are cleared.
- RUN, each cycle: candidate = group counter. If candidate matches the address of any valid pipeline stage (including the stage writing this cycle), it is a hazard, so hold the counter and leave o_rd_en low. Otherwise assert o_rd_en with o_rd_addr = candidate and advance the counter.
- Counter wrap: N_VG-1 wraps to 0 and increments o_iter. If the wrapped read was the last group of iteration MAX_ITER-1, go to DRAIN instead.
- Write-back pipeline: PIPE = VNU_LAT+1 stages of {valid, addr}. A read at cycle t produces o_wr_en/o_wr_addr at cycle t+PIPE. There is no read/write bypass; the hazard check enforces write-before-read.
- i_early_stop in RUN: no read is issued that cycle or after, o_success is latched to 1, and the FSM goes to DRAIN. It is ignored outside RUN.
- Simultaneous i_early_stop and a hazard-free read: the stop wins and the read is not issued.
- DRAIN: the pipeline retires normally. When all valid bits are 0, go to DONE.
- DONE: o_done = 1 for one cycle, o_success holds its latched value, o_busy drops in the same cycle, then return to IDLE. o_success stays valid until the next start.
- i_abort in any non-IDLE state, highest priority: clear all pipeline valid bits in the same cycle so no further o_wr_en is issued, go to IDLE, no o_done, o_busy = 0 next cycle.
- i_start outside IDLE is ignored.
- o_iter saturates at MAX_ITER-1 and is reported as the last iteration actually read.
- Throughput: with N_VG >= PIPE there are zero stalls (one read per cycle). With N_VG < PIPE, each iteration costs PIPE+1 cycles minimum per repeated group.

Decomposition:
- Shared package dgldpc_pkg: fsm state enum (sched_state_t), the default widths, and a pipeline-entry struct {valid, addr}.
- Natural sub-module: dgldpc_addr_pipe (parameterised delay line of {valid, addr} with a flush input and a per-stage compare output for hazard detection).
- The FSM, counters and the hazard OR-reduction stay in the top module.

Test Plan:
1. N_VG=16, VNU_LAT=2, MAX_ITER=8; start at cycle 0 -> reads every cycle 1..128 with no stalls; writes at cycles 4..131 with addr = read addr; o_done at 132 with o_success=0; o_iter=7.
2. N_VG=2, VNU_LAT=2, MAX_ITER=3 -> reads at cycles 1,2,5,6,9,10; writes at 4,5,8,9,12,13; o_done at 14; no cycle has o_rd_addr equal to an in-flight address.
3. Config of test 1 with i_early_stop pulsed at cycle 40 -> last read at cycle 39 (addr 6, iter 2); last write at 42; o_done at 43 with o_success=1.
4. Config of test 1 with i_abort at cycle 20 -> no o_wr_en from cycle 20 on; o_busy=0 from cycle 21; no o_done; a new i_start at 25 restarts at addr 0, iter 0.
5. i_start pulsed during RUN, and i_early_stop pulsed in IDLE -> both ignored; the sequence is identical to test 1.
6. Assert rst asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; after release the block stays in IDLE until i_start.
